fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Sequencer between the core's execute stage and the fpu block.
- Accepts one floating-point request per handshake and latches its operands and destination register.
- Drives and holds the fpu inputs, pulses fpu_go for one cycle, then waits for fpu_valid and captures the result.
- Presents the result to writeback on a valid/ready handshake.
- Only one operation is in flight at a time. `busy` stalls the core pipeline.

Parameters:
- OPW, 4: width of the fpucontrol op code.
- NOPS, 10: number of legal op codes (0..NOPS-1).
- RDW, 6: width of the destination-register tag.
- TIMEOUT, 64: maximum WAIT cycles before aborting; must be >= 2.

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  controller can accept a request
- req_op  in  OPW  op code (fpucontrol encoding)
- req_mode  in  1  rounding mode, passed to the fpu mode input
- req_a  in  32  operand a
- req_b  in  32  operand b
- req_rd  in  RDW  destination-register tag
- fpu_a  out  32  latched operand a
- fpu_b  out  32  latched operand b
- fpu_go  out  1  one-cycle start pulse
- fpu_ctrl  out  OPW  latched op code
- fpu_mode  out  1  latched mode
- fpu_c  in  32  fpu result
- fpu_valid  in  1  fpu result ready
- wb_valid  out  1  result available to writeback
- wb_ready  in  1  writeback accepts the result
- wb_data  out  32  result
- wb_rd  out  RDW  destination tag
- wb_err  out  1  result is invalid (illegal op or timeout); wb_data is 0
- busy  out  1  high when not in IDLE
- lat_last  out  8  WAIT cycles taken by the last completed op, saturating at 255

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE.
  - fpu_go, wb_valid and wb_err = 0.
  - All latched registers, wb_data, wb_rd and lat_last = 0.
  - Deasserting rstn mid-operation abandons the operation. No wb_valid is produced for it.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch op, mode, a, b and rd.
  - If req_op < NOPS, go to ISSUE.
  - If req_op >= NOPS, go directly to DONE with wb_err = 1 and wb_data = 0, and do not pulse fpu_go.
- ISSUE:
  - fpu_go = 1 for exactly this one cycle.
  - Clear the WAIT counter.
  - Go to WAIT.
- WAIT:
  - fpu_go = 0 and fpu_valid is sampled every cycle. fpu_valid is ignored in the ISSUE cycle.
  - On fpu_valid = 1: capture fpu_c into wb_data, set wb_err = 0, load lat_last = counter+1 (saturating), go to DONE.
  - If the counter reaches TIMEOUT-1 without fpu_valid: set wb_data = 0 and wb_err = 1, load lat_last = min(TIMEOUT, 255), go to DONE.
- DONE:
  - wb_valid = 1.
  - wb_data, wb_rd and wb_err stay stable until wb_ready = 1 is sampled.
  - On the handshake cycle, go to IDLE.
  - req_ready = 0 in DONE. A request needs at least one IDLE cycle.
- Held outputs: fpu_a, fpu_b, fpu_ctrl and fpu_mode hold their latched values from ISSUE through DONE, and after that until the next accept. They never change while an op is in flight.
- Latency:
  - Accept -> fpu_go: 1 cycle.
  - fpu_valid -> wb_valid: 1 cycle.
  - Best case accept -> wb_valid with a fpu_valid of latency 1: 3 cycles.
- Other outputs:
  - busy = (state != IDLE).
  - req_ready = (state == IDLE).
- A late fpu_valid arriving in DONE or IDLE after a timeout is ignored.
- Counter width is clog2(TIMEOUT)+1.

Decomposition:
- Package fpu_pkg holds:
  - Op-code localparams: FADD=0, FSUB=1, FMUL=2, FDIV=3, FSQRT=4, FTOI=5, FEQ=6, FLT=7, FLE=8, ITOF=9.
  - NOPS.
  - The state enum typedef (IDLE/ISSUE/WAIT/DONE).
- One sub-module, fpu_lat_counter: WAIT counter with clear, enable, terminal-count flag and saturating 8-bit snapshot.
- The rest is a single FSM plus registers.

Test Plan:
1. Basic add. Reset, then req op=0, a=0x3F800000, b=0x40000000, rd=5; fpu model returns valid 2 cycles after go with c=0x40400000.
   -> Exactly one fpu_go pulse; wb_valid with wb_data=0x40400000, wb_rd=5, wb_err=0; lat_last=2.
2. Writeback backpressure. Hold wb_ready=0 for 4 cycles after wb_valid.
   -> wb_valid, wb_data and wb_rd stable all 4 cycles; req_ready=0 and busy=1; handshake on the 5th cycle returns to IDLE.
3. Illegal op. Req op=12.
   -> No fpu_go; wb_valid with wb_err=1 and wb_data=0 one cycle after accept.
4. Timeout. fpu model never asserts valid, TIMEOUT=64.
   -> wb_valid with wb_err=1 and wb_data=0 after 64 WAIT cycles; lat_last=64; a later fpu_valid pulse is ignored.
5. Reset mid-operation. Assert rstn low during WAIT.
   -> All outputs zero immediately; after release, req_ready=1; a new request completes normally.
6. Back-to-back ops. Two requests presented continuously with req_valid=1, ops 2 then 6.
   -> Second is accepted only in the IDLE cycle after the first writeback; fpu_ctrl changes only on accept; results appear in order.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issue controller: op codes and sequencer states.
package fpu_pkg;

    localparam int FADD  = 0;
    localparam int FSUB  = 1;
    localparam int FMUL  = 2;
    localparam int FDIV  = 3;
    localparam int FSQRT = 4;
    localparam int FTOI  = 5;
    localparam int FEQ   = 6;
    localparam int FLT   = 7;
    localparam int FLE   = 8;
    localparam int ITOF  = 9;

    localparam int NOPS  = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/fpu_lat_counter.sv
// WAIT-cycle counter with terminal-count flag and a saturating 8-bit latency snapshot.
module fpu_lat_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       snap_ok_i,
    input  logic       snap_to_i,
    output logic       tc_o,
    output logic [7:0] lat_o
);

    localparam int         CW     = $clog2(TIMEOUT) + 1;
    localparam logic [7:0] TO_SAT = (TIMEOUT > 255) ? 8'd255 : 8'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    lat_q, lat_d;

    function automatic logic [7:0] sat8(input int v);
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CW'(1);
    end

    // The cycle that sees fpu_valid is itself a WAIT cycle, hence count + 1.
    always_comb begin
        lat_d = lat_q;
        if (snap_ok_i)
            lat_d = sat8(int'(cnt_q) + 1);
        else if (snap_to_i)
            lat_d = TO_SAT;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            lat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lat_q <= lat_d;
        end
    end

    assign tc_o  = (cnt_q == CW'(TIMEOUT - 1));
    assign lat_o = lat_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding sequencer between execute and the fpu: accept, issue, wait, write back.
module fpu_issue_ctrl #(
    parameter int OPW     = 4,
    parameter int NOPS    = fpu_pkg::NOPS,
    parameter int RDW     = 6,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [OPW-1:0] req_op,
    input  logic           req_mode,
    input  logic [31:0]    req_a,
    input  logic [31:0]    req_b,
    input  logic [RDW-1:0] req_rd,
    output logic [31:0]    fpu_a,
    output logic [31:0]    fpu_b,
    output logic           fpu_go,
    output logic [OPW-1:0] fpu_ctrl,
    output logic           fpu_mode,
    input  logic [31:0]    fpu_c,
    input  logic           fpu_valid,
    output logic           wb_valid,
    input  logic           wb_ready,
    output logic [31:0]    wb_data,
    output logic [RDW-1:0] wb_rd,
    output logic           wb_err,
    output logic           busy,
    output logic [7:0]     lat_last
);

    import fpu_pkg::*;

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           mode_q, mode_d;
    logic [31:0]    a_q, a_d, b_q, b_d, data_q, data_d;
    logic [RDW-1:0] rd_q, rd_d;
    logic           err_q, err_d;
    logic           accept, legal, tc, cnt_clr, cnt_en, snap_ok, snap_to;

    assign accept  = (state_q == IDLE) && req_valid;
    assign legal   = int'(req_op) < NOPS;
    assign snap_ok = (state_q == WAIT) && fpu_valid;
    assign snap_to = (state_q == WAIT) && !fpu_valid && tc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = legal ? ISSUE : DONE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (fpu_valid || tc) state_d = DONE;
            DONE:    if (wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        fpu_go    = (state_q == ISSUE);
        wb_valid  = (state_q == DONE);
        cnt_clr   = (state_q == ISSUE);
        cnt_en    = (state_q == WAIT);
    end

    // Illegal ops skip the fpu entirely and complete as an error straight from IDLE.
    always_comb begin
        op_d   = op_q;
        mode_d = mode_q;
        a_d    = a_q;
        b_d    = b_q;
        rd_d   = rd_q;
        data_d = data_q;
        err_d  = err_q;
        if (accept) begin
            op_d   = req_op;
            mode_d = req_mode;
            a_d    = req_a;
            b_d    = req_b;
            rd_d   = req_rd;
            if (!legal) begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end else if (snap_ok) begin
            data_d = fpu_c;
            err_d  = 1'b0;
        end else if (snap_to) begin
            data_d = '0;
            err_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q   <= '0;
            mode_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            mode_q <= mode_d;
            a_q    <= a_d;
            b_q    <= b_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    fpu_lat_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_lat (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .snap_ok_i (snap_ok),
        .snap_to_i (snap_to),
        .tc_o      (tc),
        .lat_o     (lat_last)
    );

    assign fpu_a    = a_q;
    assign fpu_b    = b_q;
    assign fpu_ctrl = op_q;
    assign fpu_mode = mode_q;
    assign wb_data  = data_q;
    assign wb_rd    = rd_q;
    assign wb_err   = err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a transaction-level reference model checked every cycle.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int TO = 64;

    logic        clk;
    logic        rstn;
    logic        req_valid, req_mode, fpu_valid, wb_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b, fpu_c;
    logic [5:0]  req_rd;
    logic [31:0] fpu_a, fpu_b, wb_data;
    logic        fpu_go, fpu_mode, wb_valid, wb_err, busy, req_ready;
    logic [3:0]  fpu_ctrl;
    logic [5:0]  wb_rd;
    logic [7:0]  lat_last;

    int checks   = 0;
    int failures = 0;
    int go_cnt   = 0;

    // fpu stand-in configuration: delay 0 means it never answers
    int          fpu_delay  = 1;
    logic [31:0] fpu_result = '0;
    bit          spur       = 0;

    fpu_issue_ctrl #(.OPW(4), .NOPS(10), .RDW(6), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_go(fpu_go), .fpu_ctrl(fpu_ctrl), .fpu_mode(fpu_mode),
        .fpu_c(fpu_c), .fpu_valid(fpu_valid),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_err(wb_err), .busy(busy), .lat_last(lat_last)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // fpu stand-in: answers fpu_delay cycles after the go pulse, or a one-off stray pulse
    initial begin
        int pend;
        pend = 0;
        fpu_valid = 0;
        fpu_c = '0;
        forever begin
            @(posedge clk);
            #1;
            fpu_valid = 0;
            if (!rstn) pend = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    fpu_valid = 1;
                    fpu_c = fpu_result;
                end
            end
            if (spur) begin
                fpu_valid = 1;
                fpu_c = 32'hDEADBEEF;
                spur = 0;
            end
            if (rstn && fpu_go && fpu_delay > 0) pend = fpu_delay;
        end
    end

    always @(negedge clk) if (fpu_go) go_cnt++;

    // Reference model: one transaction at a time, timing derived from accept cycle and fpu delay
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_legal = 0;
    int          m_acc = 0, m_when = 0;
    logic [31:0] m_a = 0, m_b = 0, m_data = 0;
    logic [3:0]  m_op = 0;
    logic        m_mode = 0, m_err = 0;
    logic [5:0]  m_rd = 0;
    logic [7:0]  m_lat = 0, m_lat_new = 0;

    always @(negedge clk) begin
        bit ev;
        cyc++;
        if (!rstn) begin
            m_busy = 0; m_a = 0; m_b = 0; m_op = 0; m_mode = 0; m_lat = 0;
            chk("rst_go", fpu_go, 0);
            chk("rst_wb_valid", wb_valid, 0);
            chk("rst_wb_err", wb_err, 0);
            chk("rst_wb_data", wb_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_fpu_a", fpu_a, 0);
            chk("rst_lat_last", lat_last, 0);
        end else begin
            if (m_busy && m_legal && cyc == m_when) m_lat = m_lat_new;
            ev = m_busy && (cyc >= m_when);
            chk("req_ready", req_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("fpu_go", fpu_go, m_busy && m_legal && (cyc == m_acc + 1));
            chk("wb_valid", wb_valid, ev);
            if (ev) begin
                chk("wb_data", wb_data, m_data);
                chk("wb_rd", wb_rd, m_rd);
                chk("wb_err", wb_err, m_err);
            end
            chk("fpu_a", fpu_a, m_a);
            chk("fpu_b", fpu_b, m_b);
            chk("fpu_ctrl", fpu_ctrl, m_op);
            chk("fpu_mode", fpu_mode, m_mode);
            chk("lat_last", lat_last, m_lat);
            if (ev && wb_ready) begin
                m_busy = 0;
            end else if (!m_busy && req_valid) begin
                m_busy = 1; m_acc = cyc;
                m_a = req_a; m_b = req_b; m_op = req_op; m_mode = req_mode; m_rd = req_rd;
                m_legal = (req_op < 10);
                if (!m_legal) begin
                    m_when = cyc + 1; m_data = 0; m_err = 1;
                end else if (fpu_delay >= 1 && fpu_delay <= TO) begin
                    m_when = cyc + 2 + fpu_delay; m_data = fpu_result; m_err = 0;
                    m_lat_new = 8'(fpu_delay);
                end else begin
                    m_when = cyc + 2 + TO; m_data = 0; m_err = 1;
                    m_lat_new = 8'(TO);
                end
            end
        end
    end

    task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] rd, input logic mode);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd; req_mode = mode;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept actual=0 required=1 at %0t", $time);
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_wb(input string nm);
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (wb_valid) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s wb_valid actual=0 required=1 at %0t", nm, $time);
        end
    endtask

    initial begin
        int g0;
        rstn = 0; req_valid = 0; req_op = 0; req_mode = 0; req_a = 0; req_b = 0; req_rd = 0;
        wb_ready = 1;
        repeat (2) @(posedge clk);
        #1 rstn = 1;

        // 1: basic add, fpu answers two cycles after go
        fpu_delay = 2; fpu_result = 32'h40400000;
        do_req(4'(FADD), 32'h3F800000, 32'h40000000, 6'd5, 1'b0);
        wait_wb("t1");
        chk("t1_data", wb_data, 32'h40400000);
        chk("t1_rd", wb_rd, 32'd5);
        chk("t1_err", wb_err, 0);
        chk("t1_lat", lat_last, 32'd2);
        chk("t1_go_count", go_cnt, 32'd1);

        // 2: writeback backpressure for four cycles
        @(posedge clk); #1 wb_ready = 0;
        fpu_delay = 3; fpu_result = 32'h12345678;
        do_req(4'(FMUL), 32'h11111111, 32'h22222222, 6'd9, 1'b1);
        wait_wb("t2");
        repeat (3) @(negedge clk);
        chk("t2_busy", busy, 1);
        chk("t2_ready", req_ready, 0);
        chk("t2_data", wb_data, 32'h12345678);
        @(posedge clk); #1 wb_ready = 1;
        @(negedge clk);
        chk("t2_valid_5th", wb_valid, 1);
        @(negedge clk);
        chk("t2_idle", req_ready, 1);

        // 3: illegal op completes as an error without touching the fpu
        g0 = go_cnt;
        do_req(4'd12, 32'hAAAA5555, 32'h5555AAAA, 6'd7, 1'b0);
        wait_wb("t3");
        chk("t3_err", wb_err, 1);
        chk("t3_data", wb_data, 0);
        chk("t3_no_go", go_cnt, g0);

        // 4: fpu never answers; a stray fpu_valid afterwards must be ignored
        @(posedge clk); #1 wb_ready = 0;
        fpu_delay = 0;
        do_req(4'(FDIV), 32'h3F800000, 32'h0, 6'd33, 1'b0);
        wait_wb("t4");
        chk("t4_err", wb_err, 1);
        chk("t4_data", wb_data, 0);
        chk("t4_lat", lat_last, 32'd64);
        spur = 1;
        repeat (3) @(negedge clk);
        chk("t4_data_after_stray", wb_data, 0);
        @(posedge clk); #1 wb_ready = 1;
        repeat (2) @(negedge clk);
        spur = 1;
        repeat (3) @(negedge clk);
        chk("t4_idle_after_stray", busy, 0);
        chk("t4_lat_kept", lat_last, 32'd64);

        // 5: reset while waiting on the fpu
        fpu_delay = 10; fpu_result = 32'h0BADF00D;
        do_req(4'(FSUB), 32'h01234567, 32'h89ABCDEF, 6'd3, 1'b1);
        repeat (2) @(negedge clk);
        #2 rstn = 0;
        #1;
        chk("t5_go", fpu_go, 0);
        chk("t5_busy", busy, 0);
        chk("t5_wb_valid", wb_valid, 0);
        chk("t5_fpu_a", fpu_a, 0);
        chk("t5_fpu_ctrl", fpu_ctrl, 0);
        chk("t5_lat", lat_last, 0);
        chk("t5_ready", req_ready, 1);
        @(negedge clk);
        @(posedge clk); #1 rstn = 1;
        repeat (15) @(negedge clk);
        fpu_delay = 1; fpu_result = 32'hCAFEF00D;
        do_req(4'(ITOF), 32'h00000007, 32'h0, 6'd12, 1'b0);
        wait_wb("t5b");
        chk("t5_new_data", wb_data, 32'hCAFEF00D);
        chk("t5_new_lat", lat_last, 32'd1);

        // 6: back-to-back requests with req_valid held high
        fpu_delay = 1; fpu_result = 32'h3C003C00;
        @(posedge clk); #1;
        req_valid = 1; req_op = 4'(FMUL); req_a = 32'h40A00000; req_b = 32'h40C00000; req_rd = 6'd10;
        req_mode = 0;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                if (req_ready) got = 1;
            end
        end
        @(posedge clk); #1;
        req_op = 4'(FEQ); req_rd = 6'd11; req_a = 32'h3F800000;
        wait_wb("t6a");
        chk("t6_first_rd", wb_rd, 32'd10);
        chk("t6_first_ctrl", fpu_ctrl, 32'(FMUL));
        @(negedge clk);
        chk("t6_idle_gap", req_ready, 1);
        @(posedge clk); #1 req_valid = 0;
        wait_wb("t6b");
        chk("t6_second_rd", wb_rd, 32'd11);
        chk("t6_second_ctrl", fpu_ctrl, 32'(FEQ));

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
